// File: rtl/frame_receiver.sv
// frame_receiver
// Extracts TLP (STP..END) and DLLP (SDP..END) frames from a per-byte symbol
// stream. Payload is written speculatively into a circular byte buffer and
// only becomes visible to the output side once END commits it; EDB or any
// framing error rolls the write pointer back to the last commit point.
// Committed frames are described by {type,len} entries in a small FIFO and
// stream out on a valid/ready byte interface with sop/eop markers.
module frame_receiver #(
    parameter int ADDR_W  = 6,
    parameter int LEN_AW  = 2,
    parameter int MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    input  logic [7:0] control_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_type,
    output logic       frame_err,
    output logic [7:0] drop_count
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NDESC  = 2 ** LEN_AW;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DPTR_W = LEN_AW + 1;
    localparam int LEN_W  = ADDR_W + 1;

    // Framing symbols; every other non-zero control code (SKP/IDL/FTS/COM)
    // is filler and is dropped without effect.
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IN_FRAME,
        ST_DROP
    } state_t;

    state_t             state_q, state_d;
    logic               type_q, type_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [PTR_W-1:0]   spec_ptr_q, spec_ptr_d;
    logic [PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DPTR_W-1:0]  desc_wr_q, desc_wr_d;
    logic [DPTR_W-1:0]  desc_rd_q, desc_rd_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         drop_count_q, drop_count_d;

    logic [7:0]         data_mem      [DEPTH];
    logic [LEN_W-1:0]   desc_len_mem  [NDESC];
    logic               desc_type_mem [NDESC];

    logic               buf_we;
    logic               desc_we;
    logic               err;
    logic               is_data;
    logic               desc_full;
    logic               desc_empty;
    logic               buf_full;
    logic               len_at_max;
    logic [LEN_W-1:0]   head_len;
    logic               head_last;
    logic               xfer;

    // Full/empty from pointers one bit wider than the address: equal low
    // bits with differing MSB means the ring has wrapped once (full).
    assign desc_empty = (desc_wr_q == desc_rd_q);
    assign desc_full  = (desc_wr_q[LEN_AW] != desc_rd_q[LEN_AW]) &&
                        (desc_wr_q[LEN_AW-1:0] == desc_rd_q[LEN_AW-1:0]);
    assign buf_full   = (spec_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (spec_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign len_at_max = (len_q == LEN_W'(MAX_LEN));
    assign is_data    = (control_in == 8'h00);

    assign head_len   = desc_len_mem[desc_rd_q[LEN_AW-1:0]];
    assign head_last  = (cnt_q == head_len - LEN_W'(1));
    assign xfer       = !desc_empty && out_ready;

    // Output view: head byte of the oldest committed frame, zero when idle.
    assign out_valid  = !desc_empty;
    assign out_data   = out_valid ? data_mem[rd_ptr_q[ADDR_W-1:0]] : 8'h00;
    assign out_type   = out_valid && desc_type_mem[desc_rd_q[LEN_AW-1:0]];
    assign out_sop    = out_valid && (cnt_q == '0);
    assign out_eop    = out_valid && head_last;
    assign frame_err  = frame_err_q;
    assign drop_count = drop_count_q;

    // Receive FSM: framing decisions, speculative writes, commit and rollback.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise any
        // path that skips an assignment infers a latch.
        state_d      = state_q;
        type_d       = type_q;
        len_d        = len_q;
        spec_ptr_d   = spec_ptr_q;
        commit_ptr_d = commit_ptr_q;
        desc_wr_d    = desc_wr_q;
        buf_we       = 1'b0;
        desc_we      = 1'b0;
        err          = 1'b0;

        if (valid_in) begin
            unique case (state_q)
                ST_IDLE, ST_DROP: begin
                    if (control_in == SYM_STP || control_in == SYM_SDP) begin
                        state_d = ST_IN_FRAME;
                        type_d  = (control_in == SYM_SDP);
                        len_d   = '0;
                    end else if (control_in == SYM_END || control_in == SYM_EDB) begin
                        // A stray terminator is only an error outside DROP;
                        // in DROP it just closes the already-reported frame.
                        err     = (state_q == ST_IDLE);
                        state_d = ST_IDLE;
                    end
                end
                ST_IN_FRAME: begin
                    if (is_data) begin
                        if (len_at_max || buf_full) begin
                            spec_ptr_d = commit_ptr_q;
                            err        = 1'b1;
                            state_d    = ST_DROP;
                        end else begin
                            buf_we     = 1'b1;
                            spec_ptr_d = spec_ptr_q + PTR_W'(1);
                            len_d      = len_q + LEN_W'(1);
                        end
                    end else if (control_in == SYM_STP || control_in == SYM_SDP) begin
                        // Restart: abandon the open frame and begin a new one.
                        spec_ptr_d = commit_ptr_q;
                        err        = 1'b1;
                        type_d     = (control_in == SYM_SDP);
                        len_d      = '0;
                    end else if (control_in == SYM_END) begin
                        if (len_q != '0 && !desc_full) begin
                            desc_we      = 1'b1;
                            desc_wr_d    = desc_wr_q + DPTR_W'(1);
                            commit_ptr_d = spec_ptr_q;
                        end else begin
                            spec_ptr_d = commit_ptr_q;
                            err        = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else if (control_in == SYM_EDB) begin
                        spec_ptr_d = commit_ptr_q;
                        err        = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        frame_err_d  = err;
        drop_count_d = (err && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    end

    // Output side: advance read pointer and in-frame byte counter per transfer.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        desc_rd_d = desc_rd_q;
        if (xfer) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (head_last) begin
                cnt_d     = '0;
                desc_rd_d = desc_rd_q + DPTR_W'(1);
            end else begin
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
    end

    // State, pointer and status registers.
    always_ff @(posedge clk or negedge reset_L) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of all others.
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            type_q       <= 1'b0;
            len_q        <= '0;
            spec_ptr_q   <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            desc_wr_q    <= '0;
            desc_rd_q    <= '0;
            frame_err_q  <= 1'b0;
            drop_count_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            len_q        <= len_d;
            spec_ptr_q   <= spec_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            desc_wr_q    <= desc_wr_d;
            desc_rd_q    <= desc_rd_d;
            frame_err_q  <= frame_err_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Payload and descriptor storage writes.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the pointers guard every read,
        // so stale contents are never observed.
        if (buf_we) begin
            data_mem[spec_ptr_q[ADDR_W-1:0]] <= data_in;
        end
        if (desc_we) begin
            desc_len_mem[desc_wr_q[LEN_AW-1:0]]  <= len_q;
            desc_type_mem[desc_wr_q[LEN_AW-1:0]] <= type_q;
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_frame_receiver;

    localparam int MAX_LEN = 32;
    localparam int DEPTH   = 64;
    localparam int NDESC   = 4;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] ENDS = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] SKP = 8'h1C;

    localparam int M_IDLE = 0;
    localparam int M_IN   = 1;
    localparam int M_DROP = 2;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       valid_in;
    logic [7:0] data_in;
    logic [7:0] control_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sop;
    logic       out_eop;
    logic       out_type;
    logic       frame_err;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    frame_receiver #(.ADDR_W(6), .LEN_AW(2), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .control_in (control_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_type   (out_type),
        .frame_err  (frame_err),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       typ;
    } beat_t;

    // Scoreboard of expected output bytes, filled by the model on commit.
    beat_t exp_q[$];

    // Reference model state.
    int         m_state;
    logic       m_type;
    logic [7:0] spec_q[$];
    int         m_lens[$];
    int         m_cnt;
    int         m_bytes;
    int         m_drops;
    logic       exp_err;

    int checks = 0;
    int errors = 0;
    logic rdy_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_type  = 1'b0;
        spec_q.delete();
        m_lens.delete();
        m_cnt   = 0;
        m_bytes = 0;
        m_drops = 0;
        exp_err = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the reference model, using the inputs being applied.
    task automatic model_step();
        int   frames = m_lens.size();
        int   stored = m_bytes + spec_q.size();
        logic err    = 1'b0;
        int   n;
        if (out_ready && frames > 0) begin
            m_bytes--;
            m_cnt++;
            if (m_cnt == m_lens[0]) begin
                void'(m_lens.pop_front());
                m_cnt = 0;
            end
        end
        if (valid_in) begin
            if (m_state != M_IN) begin
                if (control_in == STP || control_in == SDP) begin
                    m_state = M_IN;
                    m_type  = (control_in == SDP);
                    spec_q.delete();
                end else if (control_in == ENDS || control_in == EDB) begin
                    if (m_state == M_IDLE) err = 1'b1;
                    m_state = M_IDLE;
                end
            end else if (control_in == 8'h00) begin
                if (spec_q.size() == MAX_LEN || stored == DEPTH) begin
                    err = 1'b1;
                    spec_q.delete();
                    m_state = M_DROP;
                end else begin
                    spec_q.push_back(data_in);
                end
            end else if (control_in == STP || control_in == SDP) begin
                err    = 1'b1;
                m_type = (control_in == SDP);
                spec_q.delete();
            end else if (control_in == ENDS) begin
                n = spec_q.size();
                if (n > 0 && frames < NDESC) begin
                    for (int i = 0; i < n; i++)
                        exp_q.push_back('{data: spec_q[i], sop: (i == 0), eop: (i == n - 1), typ: m_type});
                    m_lens.push_back(n);
                    m_bytes += n;
                end else begin
                    err = 1'b1;
                end
                spec_q.delete();
                m_state = M_IDLE;
            end else if (control_in == EDB) begin
                err = 1'b1;
                spec_q.delete();
                m_state = M_IDLE;
            end
        end
        exp_err = err;
        if (err && m_drops < 255) m_drops++;
    endtask

    // Apply one cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [7:0] c, input logic [7:0] d);
        valid_in   = v;
        control_in = c;
        data_in    = d;
        out_ready  = rdy_g;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00);
    endtask

    task automatic rand_cycle(input int valid_pct, input int end_pct, input int ready_pct);
        logic [7:0] fill [4];
        int         r;
        logic [7:0] c;
        fill = '{8'h1C, 8'h7C, 8'h3C, 8'hBC};
        rdy_g = ($urandom_range(0, 99) < ready_pct);
        r = $urandom_range(0, 99);
        if (r < end_pct)           c = ($urandom_range(0, 4) == 0) ? EDB : ENDS;
        else if (r < end_pct + 6)  c = $urandom_range(0, 1) ? SDP : STP;
        else if (r < end_pct + 10) c = fill[$urandom_range(0, 3)];
        else                       c = 8'h00;
        cycle($urandom_range(0, 99) < valid_pct, c, 8'($urandom_range(0, 255)));
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_out_type", out_type, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_drop_count", drop_count, 0);
    endtask

    // Monitor: mid-cycle comparison of DUT outputs against the model and
    // scoreboard; pops one expected beat per accepted output byte.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (reset_L) begin
                check("out_valid", out_valid, (m_lens.size() > 0));
                check("frame_err", frame_err, exp_err);
                check("drop_count", drop_count, m_drops);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h with nothing expected at %0t", out_data, $time);
                    end else begin
                        b = exp_q.pop_front();
                        check("out_data", out_data, b.data);
                        check("out_sop", out_sop, b.sop);
                        check("out_eop", out_eop, b.eop);
                        check("out_type", out_type, b.typ);
                    end
                end
            end
        end
    end

    initial begin
        reset_L    = 1'b0;
        valid_in   = 1'b0;
        data_in    = 8'h00;
        control_in = 8'h00;
        out_ready  = 1'b0;
        rdy_g      = 1'b1;
        model_reset();
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1 reset_L = 1'b1;

        // Basic TLP of three bytes.
        rdy_g = 1'b1;
        cycle(1, STP, 0); cycle(1, 0, 8'hAA); cycle(1, 0, 8'hBB); cycle(1, 0, 8'hCC); cycle(1, ENDS, 0);
        idle(5);

        // DLLP aborted by EDB, then a good 1-byte DLLP.
        cycle(1, SDP, 0); cycle(1, 0, 8'h11); cycle(1, EDB, 0);
        cycle(1, SDP, 0); cycle(1, 0, 8'h22); cycle(1, ENDS, 0);
        idle(4);

        // Oversize frame dropped, terminator absorbed by DROP, then 55.
        cycle(1, STP, 0);
        for (int i = 0; i <= MAX_LEN; i++) cycle(1, 0, 8'(i));
        cycle(1, ENDS, 0);
        cycle(1, STP, 0); cycle(1, 0, 8'h55); cycle(1, ENDS, 0);
        idle(4);

        // Descriptor FIFO fills with output stalled; fifth frame dropped.
        rdy_g = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, STP, 0); cycle(1, 0, 8'hD0 + 8'(i)); cycle(1, ENDS, 0);
        end
        idle(3);
        rdy_g = 1'b1;
        idle(8);

        // Restart by a second STP; SKP inside the frame is not stored.
        cycle(1, STP, 0); cycle(1, 0, 8'h01); cycle(1, SKP, 0); cycle(1, 0, 8'h02);
        cycle(1, STP, 0); cycle(1, 0, 8'h03); cycle(1, ENDS, 0);
        idle(4);

        // Stray END, then reset asserted mid-frame.
        cycle(1, ENDS, 0);
        cycle(1, STP, 0); cycle(1, 0, 8'h99);
        reset_L = 1'b0;
        model_reset();
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1 reset_L = 1'b1;
        idle(2);
        cycle(1, SDP, 0); cycle(1, 0, 8'h77); cycle(1, ENDS, 0);
        idle(4);

        // Randomized traffic with varied validity, frame length and backpressure.
        for (int i = 0; i < 1200; i++) rand_cycle(85, 12, 90);
        for (int i = 0; i < 1200; i++) rand_cycle(90, 3, 25);
        for (int i = 0; i < 1200; i++) rand_cycle(50, 8, 60);
        for (int i = 0; i < 800; i++)  rand_cycle(95, 2, 10);

        // Drain with a bounded cycle budget.
        rdy_g = 1'b1;
        for (int i = 0; i < 600 && (exp_q.size() != 0 || m_lens.size() != 0); i++) idle(1);
        idle(2);
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
